// File: rtl/fa4_seq_adder_ctrl_if.sv
// -----------------------------------------------------------------------------
// fa4_seq_adder_ctrl_if
//   Handshake bundle for the sequential nibble adder.
//   Request side : in_valid / in_ready with operands a, b and carry-in ci.
//   Response side: out_valid / out_ready with sum s and carry-out co.
//   busy reports that an operation is in flight or waiting to be taken.
//   master modport: the producer/consumer around the adder.
//   slave modport : the adder itself.
// -----------------------------------------------------------------------------
interface fa4_seq_adder_ctrl_if #(
    parameter int WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             busy;

    modport master (
        output in_valid, a, b, ci, out_ready,
        input  in_ready, out_valid, s, co, busy
    );

    modport slave (
        input  in_valid, a, b, ci, out_ready,
        output in_ready, out_valid, s, co, busy
    );
endinterface

// File: rtl/fa4_seq_adder_ctrl.sv
// -----------------------------------------------------------------------------
// fa4_seq_adder_ctrl
//   Adds two WIDTH-bit operands plus a carry-in by stepping one 4-bit adder
//   slice across the operands, least-significant nibble first. The carry
//   between nibbles is held in a register, so an operation takes WIDTH/4
//   RUN cycles.
//
//   Ports:
//     clk  in  rising-edge clock
//     rst  in  synchronous active-high reset; aborts any operation in flight
//     bus  slave side of fa4_seq_adder_ctrl_if:
//            in_valid/in_ready + a, b, ci   request (accepted only in IDLE)
//            out_valid/out_ready + s, co    result ({co,s} = a + b + ci)
//            busy                           high in RUN or DONE
// -----------------------------------------------------------------------------
module fa4_seq_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    fa4_seq_adder_ctrl_if.slave   bus
);

    localparam int NSLICE = WIDTH / 4;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NSLICE - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [CW-1:0]    cnt_r;
    logic             carry_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] s_r;
    logic             co_r;

    logic [3:0]       slice_a_s;
    logic [3:0]       slice_b_s;
    logic [3:0]       slice_sum_s;
    logic             slice_co_s;
    logic [WIDTH-1:0] s_next_s;

    // Select the operand nibbles addressed by the slice counter.
    always_comb begin
        slice_a_s = 4'd0;
        slice_b_s = 4'd0;
        for (int i = 0; i < NSLICE; i++) begin
            if (cnt_r == i[CW-1:0]) begin
                slice_a_s = a_r[4*i +: 4];
                slice_b_s = b_r[4*i +: 4];
            end else begin
                slice_a_s = slice_a_s;
                slice_b_s = slice_b_s;
            end
        end
    end

    // The one shared 4-bit adder slice.
    fa4_mbit u_slice (
        .a  (slice_a_s),
        .b  (slice_b_s),
        .ci (carry_r),
        .s  (slice_sum_s),
        .co (slice_co_s)
    );

    // Merge the fresh slice sum into its nibble of the sum register.
    always_comb begin
        s_next_s = s_r;
        for (int i = 0; i < NSLICE; i++) begin
            if (cnt_r == i[CW-1:0]) begin
                s_next_s[4*i +: 4] = slice_sum_s;
            end else begin
                s_next_s[4*i +: 4] = s_r[4*i +: 4];
            end
        end
    end

    // Control FSM and datapath registers; reset clears any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CW{1'b0}};
            carry_r <= 1'b0;
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            s_r     <= {WIDTH{1'b0}};
            co_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        a_r     <= bus.a;
                        b_r     <= bus.b;
                        carry_r <= bus.ci;
                        cnt_r   <= {CW{1'b0}};
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    s_r     <= s_next_s;
                    carry_r <= slice_co_s;
                    if (cnt_r == LAST_CNT) begin
                        // Last nibble: its carry-out is the result carry.
                        co_r    <= slice_co_s;
                        cnt_r   <= {CW{1'b0}};
                        state_r <= ST_DONE;
                    end else begin
                        cnt_r   <= cnt_r + CW'(1);
                        state_r <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= {CW{1'b0}};
                end
            endcase
        end
    end

    // Handshake flags are pure decodes of the state register.
    assign bus.in_ready  = (state_r == ST_IDLE);
    assign bus.out_valid = (state_r == ST_DONE);
    assign bus.busy      = (state_r != ST_IDLE);
    assign bus.s         = s_r;
    assign bus.co        = co_r;

endmodule

// -----------------------------------------------------------------------------
// fa4_mbit
//   Combinational 4-bit ripple adder slice: {co,s} = a + b + ci.
//   Ports: a, b (4-bit operands), ci (carry-in), s (4-bit sum), co (carry-out).
// -----------------------------------------------------------------------------
module fa4_mbit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    // One-bit full adder; returns {carry, sum}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
        return {(x & y) | (x & c) | (y & c), x ^ y ^ c};
    endfunction

    logic       c_s;
    logic [1:0] fa_s;

    // Ripple the carry through the four bit positions.
    always_comb begin
        c_s  = ci;
        fa_s = 2'b00;
        s    = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            fa_s = full_add(a[i], b[i], c_s);
            s[i] = fa_s[0];
            c_s  = fa_s[1];
        end
        co = c_s;
    end

endmodule

// File: tb/tb_fa4_seq_adder_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fa4_seq_adder_ctrl
//   Directed and random checks of the sequential nibble adder at WIDTH=16 and
//   WIDTH=4. Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_fa4_seq_adder_ctrl;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    fa4_seq_adder_ctrl_if #(.WIDTH(16)) bus16 ();
    fa4_seq_adder_ctrl_if #(.WIDTH(4))  bus4  ();

    fa4_seq_adder_ctrl #(.WIDTH(16)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16.slave)
    );

    fa4_seq_adder_ctrl #(.WIDTH(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Guard against a stuck run.
    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one 16-bit operation, scramble the inputs while it runs,
    // then check latency and result (result stays presented afterwards).
    task automatic op16(input logic [15:0] ta, input logic [15:0] tb_v, input logic tci,
                        input logic [16:0] exp, input string tag);
        int n;
        bus16.a        = ta;
        bus16.b        = tb_v;
        bus16.ci       = tci;
        bus16.in_valid = 1'b1;
        bus16.out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus16.in_valid = 1'b0;
        bus16.a        = ~ta;
        bus16.b        = ~tb_v;
        bus16.ci       = ~tci;
        n = 0;
        while (!bus16.out_valid && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk({tag, "_lat"}, 32'(n), 32'd4);
        chk({tag, "_sum"}, {15'd0, bus16.co, bus16.s}, {15'd0, exp});
        chk({tag, "_busy"}, {31'd0, bus16.busy}, 32'd1);
    endtask

    // Take the presented result and confirm the return to IDLE.
    task automatic release16(input string tag);
        bus16.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus16.out_ready = 1'b0;
        chk({tag, "_rdy"}, {30'd0, bus16.in_ready, bus16.out_valid}, 32'd2);
    endtask

    initial begin
        logic [15:0] ra, rb;
        logic        rci;
        logic [16:0] rexp;
        logic [3:0]  qa, qb;
        logic [4:0]  qexp;
        int          n;
        int          bad;

        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus16.in_valid = 1'b0; bus16.a = 16'h0000; bus16.b = 16'h0000;
        bus16.ci = 1'b0; bus16.out_ready = 1'b0;
        bus4.in_valid = 1'b0; bus4.a = 4'h0; bus4.b = 4'h0;
        bus4.ci = 1'b0; bus4.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state.
        chk("rst_flags", {29'd0, bus16.in_ready, bus16.busy, bus16.out_valid}, 32'd4);
        chk("rst_sum", {15'd0, bus16.co, bus16.s}, 32'd0);
        chk("rst_flags4", {29'd0, bus4.in_ready, bus4.busy, bus4.out_valid}, 32'd4);

        // Basic adds.
        op16(16'h1234, 16'h4321, 1'b0, 17'h05555, "t1");
        release16("t1");
        op16(16'hFFFF, 16'h0001, 1'b0, 17'h10000, "t2");
        release16("t2");
        op16(16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF, "t3");
        release16("t3");

        // Backpressure: result held, new requests ignored.
        op16(16'hA5A5, 16'h0F0F, 1'b0, 17'h0B4B4, "t4");
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            bus16.in_valid = i[0];
            bus16.a = 16'h1111 * 16'(i + 1);
            bus16.b = 16'h2222;
            @(posedge clk);
            @(negedge clk);
            if ({bus16.co, bus16.s} !== 17'h0B4B4 || bus16.out_valid !== 1'b1
                || bus16.in_ready !== 1'b0)
                bad++;
        end
        bus16.in_valid = 1'b0;
        chk("t4_hold", 32'(bad), 32'd0);
        release16("t4");
        chk("t4_kept", {15'd0, bus16.co, bus16.s}, 32'h0B4B4);

        // Reset mid-run with cnt==2.
        bus16.a = 16'h7777; bus16.b = 16'h8888; bus16.ci = 1'b1;
        bus16.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus16.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("t5_flags", {29'd0, bus16.in_ready, bus16.busy, bus16.out_valid}, 32'd4);
        chk("t5_clr", {15'd0, bus16.co, bus16.s}, 32'd0);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus16.out_valid !== 1'b0) bad++;
        end
        chk("t5_noval", 32'(bad), 32'd0);
        op16(16'h0F0F, 16'h00F1, 1'b1, 17'h01001, "t5b");
        release16("t5b");

        // Reset wins over a simultaneous request.
        bus16.in_valid = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus16.in_valid = 1'b0;
        chk("rst_vs_req", {30'd0, bus16.in_ready, bus16.busy}, 32'd2);

        // Random 16-bit operations with random result stalls.
        bad = 0;
        for (int k = 0; k < 200; k++) begin
            ra = 16'($urandom); rb = 16'($urandom); rci = 1'($urandom);
            rexp = {1'b0, ra} + {1'b0, rb} + {16'd0, rci};
            bus16.a = ra; bus16.b = rb; bus16.ci = rci;
            bus16.in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus16.in_valid = 1'b0;
            n = 0;
            while (!bus16.out_valid && n < 20) begin
                @(posedge clk);
                n++;
                @(negedge clk);
            end
            if (n != 4 || {bus16.co, bus16.s} !== rexp) bad++;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if ({bus16.co, bus16.s} !== rexp) bad++;
            bus16.out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus16.out_ready = 1'b0;
        end
        chk("rand16", 32'(bad), 32'd0);

        // WIDTH=4: one RUN cycle.
        bus4.a = 4'hF; bus4.b = 4'h1; bus4.ci = 1'b0;
        bus4.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus4.in_valid = 1'b0;
        n = 0;
        while (!bus4.out_valid && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        chk("w4_lat", 32'(n), 32'd1);
        chk("w4_sum", {27'd0, bus4.co, bus4.s}, 32'h10);
        bus4.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus4.out_ready = 1'b0;
        chk("w4_idle", {30'd0, bus4.in_ready, bus4.out_valid}, 32'd2);

        bad = 0;
        for (int k = 0; k < 60; k++) begin
            qa = 4'($urandom); qb = 4'($urandom); rci = 1'($urandom);
            qexp = {1'b0, qa} + {1'b0, qb} + {4'd0, rci};
            bus4.a = qa; bus4.b = qb; bus4.ci = rci;
            bus4.in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus4.in_valid = 1'b0;
            n = 0;
            while (!bus4.out_valid && n < 20) begin
                @(posedge clk);
                n++;
                @(negedge clk);
            end
            if (n != 1 || {bus4.co, bus4.s} !== qexp) bad++;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            bus4.out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus4.out_ready = 1'b0;
        end
        chk("rand4", 32'(bad), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
